// File: rtl/serv_rf_ram_arb_pkg.sv
// Shared types for the RF RAM arbiter.
//   main_state_t : power-up sequencer (START -> CLEAR -> RUN)
//   dbg_state_t  : debug port transaction tracker
//   rf_depth()   : RAM word count, same formula as the RF top level
package serv_rf_ram_arb_pkg;

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2
    } main_state_t;

    typedef enum logic [1:0] {
        DBG_IDLE  = 2'd0,
        DBG_WACK  = 2'd1,
        DBG_RWAIT = 2'd2
    } dbg_state_t;

    // 32 GPRs plus optional CSRs, each 32 bits, split into width-bit words.
    function automatic int rf_depth(input int width, input int csr_regs);
        return 32 * (32 + csr_regs) / width;
    endfunction

endpackage

// File: rtl/serv_rf_ram_arb.sv
// RF RAM arbiter between serv_rf_ram_if (core) and serv_rf_ram.
// After reset it optionally zeroes every RAM word while o_init_done is low,
// then forwards core traffic with absolute priority. A debug port borrows
// the RAM write or read port only in cycles where the core leaves it idle.
//
// Ports
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   o_init_done           RAM ready; core must be held in reset while low
//   i_core_*              core write/read port (passed through in RUN)
//   o_core_rdata          RAM read data straight to the core
//   i_dbg_req/we/addr/wdata  debug request, held stable until o_dbg_ack
//   o_dbg_ack             one-cycle completion pulse
//   o_dbg_rdata           registered debug read data, holds between reads
//   o_ram_*, i_ram_rdata  RAM side (read data valid the cycle after ren)
module serv_rf_ram_arb
    import serv_rf_ram_arb_pkg::*;
#(
    parameter int width          = 2,
    parameter int csr_regs       = 4,
    parameter bit CLEAR_ON_RESET = 1'b1,
    localparam int depth         = rf_depth(width, csr_regs),
    localparam int aw            = $clog2(depth)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    output logic             o_init_done,
    input  logic [aw-1:0]    i_core_waddr,
    input  logic [width-1:0] i_core_wdata,
    input  logic             i_core_wen,
    input  logic [aw-1:0]    i_core_raddr,
    input  logic             i_core_ren,
    output logic [width-1:0] o_core_rdata,
    input  logic             i_dbg_req,
    input  logic             i_dbg_we,
    input  logic [aw-1:0]    i_dbg_addr,
    input  logic [width-1:0] i_dbg_wdata,
    output logic             o_dbg_ack,
    output logic [width-1:0] o_dbg_rdata,
    output logic [aw-1:0]    o_ram_waddr,
    output logic [width-1:0] o_ram_wdata,
    output logic             o_ram_wen,
    output logic [aw-1:0]    o_ram_raddr,
    output logic             o_ram_ren,
    input  logic [width-1:0] i_ram_rdata
);

    localparam logic [aw-1:0] CNT_LAST = aw'(depth - 1);
    // One extra bit so the bound compares correctly even when depth == 2**aw.
    localparam logic [aw:0]   DEPTH_W  = (aw + 1)'(depth);

    main_state_t      state, state_nxt;
    dbg_state_t       dbg_state, dbg_nxt;
    logic [aw-1:0]    cnt;
    logic             init_done_q;
    logic             dbg_ack_q;
    logic [width-1:0] dbg_rdata_q;

    logic dbg_can_issue;
    logic dbg_in_range;
    logic dbg_wr_issue;
    logic dbg_rd_issue;

    // ------------------------------------------------------------------
    // Main sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= ST_START;
            cnt         <= '0;
            init_done_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            init_done_q <= (state_nxt == ST_RUN);
            if (state == ST_CLEAR)
                cnt <= cnt + aw'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_START: state_nxt = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            ST_CLEAR: if (cnt == CNT_LAST) state_nxt = ST_RUN;
            ST_RUN:   state_nxt = ST_RUN;
            default:  state_nxt = ST_START;
        endcase
    end

    // ------------------------------------------------------------------
    // RAM port steering
    // ------------------------------------------------------------------
    // A debug request is only considered while the tracker is idle and not
    // in the cycle its previous read ack is showing: the requester still
    // holds req during the ack cycle, and it must not be issued twice.
    assign dbg_can_issue = (state == ST_RUN) && (dbg_state == DBG_IDLE) &&
                           !dbg_ack_q && i_dbg_req;
    assign dbg_in_range  = ({1'b0, i_dbg_addr} < DEPTH_W);

    always_comb begin
        o_ram_wen    = 1'b0;
        o_ram_waddr  = '0;
        o_ram_wdata  = '0;
        o_ram_ren    = 1'b0;
        o_ram_raddr  = '0;
        dbg_wr_issue = 1'b0;
        dbg_rd_issue = 1'b0;
        case (state)
            ST_CLEAR: begin
                o_ram_wen   = 1'b1;
                o_ram_waddr = cnt;
            end
            ST_RUN: begin
                if (i_core_wen) begin
                    o_ram_wen   = 1'b1;
                    o_ram_waddr = i_core_waddr;
                    o_ram_wdata = i_core_wdata;
                end else if (dbg_can_issue && i_dbg_we) begin
                    // Out-of-range writes still complete with an ack but
                    // never reach the RAM.
                    dbg_wr_issue = 1'b1;
                    o_ram_wen    = dbg_in_range;
                    o_ram_waddr  = i_dbg_addr;
                    o_ram_wdata  = i_dbg_wdata;
                end

                if (i_core_ren) begin
                    o_ram_ren   = 1'b1;
                    o_ram_raddr = i_core_raddr;
                end else if (dbg_can_issue && !i_dbg_we) begin
                    dbg_rd_issue = 1'b1;
                    o_ram_ren    = dbg_in_range;
                    o_ram_raddr  = i_dbg_addr;
                end
            end
            default: ;
        endcase
    end

    // Debug reads only use cycles where the core issued no read, so the
    // core never samples the debug data and a plain passthrough suffices.
    assign o_core_rdata = i_ram_rdata;

    // ------------------------------------------------------------------
    // Debug transaction tracker
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            dbg_state   <= DBG_IDLE;
            dbg_ack_q   <= 1'b0;
            dbg_rdata_q <= '0;
        end else begin
            dbg_state <= dbg_nxt;
            // Write acks in the cycle after issue; read acks after the RAM
            // data has been captured during RWAIT.
            dbg_ack_q <= dbg_wr_issue || (dbg_state == DBG_RWAIT);
            // Address is still held stable by the requester during RWAIT.
            if (dbg_state == DBG_RWAIT)
                dbg_rdata_q <= dbg_in_range ? i_ram_rdata : '0;
        end
    end

    always_comb begin
        dbg_nxt = dbg_state;
        case (dbg_state)
            DBG_IDLE: begin
                if (dbg_wr_issue)
                    dbg_nxt = DBG_WACK;
                else if (dbg_rd_issue)
                    dbg_nxt = DBG_RWAIT;
            end
            DBG_WACK:  dbg_nxt = DBG_IDLE;
            DBG_RWAIT: dbg_nxt = DBG_IDLE;
            default:   dbg_nxt = DBG_IDLE;
        endcase
    end

    assign o_init_done = init_done_q;
    assign o_dbg_ack   = dbg_ack_q;
    assign o_dbg_rdata = dbg_rdata_q;

endmodule
